// File: rtl/phase_trig_pkg.sv
// -----------------------------------------------------------------------------
// phase_trig_pkg
// Shared constants for the phase-accumulator trigger generator: the meaning of
// the SEL update-mode bit and the default datapath widths.
// -----------------------------------------------------------------------------
package phase_trig_pkg;

    // Tuning-word update mode, sampled on the accept edge only.
    localparam logic SEL_IMMEDIATE = 1'b0;  // load straight into tw_active
    localparam logic SEL_COHERENT  = 1'b1;  // park in tw_pend until next wrap

    // Default widths. TUNE_WIDTH and PA_OUT_WIDTH must not exceed PA_WIDTH.
    localparam int PA_WIDTH_DEF     = 32;
    localparam int TUNE_WIDTH_DEF   = 32;
    localparam int PA_OUT_WIDTH_DEF = 8;

endpackage : phase_trig_pkg

// File: rtl/phase_acc.sv
// -----------------------------------------------------------------------------
// phase_acc
// Phase accumulator core: adds the active tuning word into the accumulator
// every enabled cycle and registers the carry-out as a one-cycle wrap pulse.
//
// Ports
//   clk        in   sole clock, rising edge
//   n_RST      in   asynchronous active-low reset
//   en         in   accumulate enable; when low acc holds and trig is 0
//   tw_active  in   tuning word added each enabled cycle (zero-extended)
//   phase      out  top PA_OUT_WIDTH bits of the accumulator register
//   trig       out  registered carry-out of the previous addition
//   carry      out  combinational carry of the addition happening this cycle,
//                   used by the parent to apply a pending word on the wrap edge
// -----------------------------------------------------------------------------
module phase_acc
    import phase_trig_pkg::*;
#(
    parameter int PA_WIDTH     = PA_WIDTH_DEF,
    parameter int TUNE_WIDTH   = TUNE_WIDTH_DEF,
    parameter int PA_OUT_WIDTH = PA_OUT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    n_RST,
    input  logic                    en,
    input  logic [TUNE_WIDTH-1:0]   tw_active,
    output logic [PA_OUT_WIDTH-1:0] phase,
    output logic                    trig,
    output logic                    carry
);

    logic [PA_WIDTH-1:0] acc_q;
    logic [PA_WIDTH:0]   sum_d;   // one extra bit holds the carry-out
    logic                trig_q;

    // Zero-extending cast keeps this legal even when TUNE_WIDTH == PA_WIDTH.
    assign sum_d = {1'b0, acc_q} + (PA_WIDTH + 1)'(tw_active);
    assign carry = en & sum_d[PA_WIDTH];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            acc_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            if (en) begin
                acc_q <= sum_d[PA_WIDTH-1:0];
            end
            // carry is already gated by en, so trig falls to 0 while disabled.
            trig_q <= carry;
        end
    end

    assign phase = acc_q[PA_WIDTH-1 -: PA_OUT_WIDTH];
    assign trig  = trig_q;

endmodule : phase_acc

// File: rtl/phase_trig_gen.sv
// -----------------------------------------------------------------------------
// phase_trig_gen
// Phase-accumulator trigger generator feeding the filter's sample-and-hold.
// Turns a frequency tuning word into a one-cycle wrap pulse (trig) and a
// truncated phase word. New tuning words arrive on a valid/ready handshake and
// are applied either immediately (SEL=0) or at the next accumulator wrap
// (SEL=1) so the output period never contains a partial cycle.
//
// Ports
//   clk        in   sole clock, rising edge
//   n_RST      in   asynchronous active-low reset
//   en         in   accumulate enable
//   SEL        in   update mode, 0 = immediate, 1 = at next wrap
//   tw_in      in   tuning word offered for load
//   tw_valid   in   tw_in is valid
//   tw_ready   out  a tuning word can be accepted (no word pending)
//   tw_active  out  tuning word currently being accumulated
//   phase_out  out  acc[PA_WIDTH-1 -: PA_OUT_WIDTH]
//   trig       out  one-cycle pulse after each accumulator wrap
// -----------------------------------------------------------------------------
module phase_trig_gen
    import phase_trig_pkg::*;
#(
    parameter int PA_WIDTH     = PA_WIDTH_DEF,
    parameter int TUNE_WIDTH   = TUNE_WIDTH_DEF,
    parameter int PA_OUT_WIDTH = PA_OUT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    n_RST,
    input  logic                    en,
    input  logic                    SEL,
    input  logic [TUNE_WIDTH-1:0]   tw_in,
    input  logic                    tw_valid,
    output logic                    tw_ready,
    output logic [TUNE_WIDTH-1:0]   tw_active,
    output logic [PA_OUT_WIDTH-1:0] phase_out,
    output logic                    trig
);

    logic [TUNE_WIDTH-1:0] tw_active_q, tw_active_d;
    logic [TUNE_WIDTH-1:0] tw_pend_q,   tw_pend_d;
    logic                  pend_q,      pend_d;
    logic                  accept;
    logic                  carry;

    assign tw_ready = !pend_q;
    assign accept   = tw_valid && !pend_q;

    // NOTE: every signal written here gets a default first, so paths that do
    // not assign it cannot infer a latch.
    always_comb begin
        tw_active_d = tw_active_q;
        tw_pend_d   = tw_pend_q;
        pend_d      = pend_q;

        if (accept) begin
            if (SEL == SEL_COHERENT) begin
                tw_pend_d = tw_in;
                pend_d    = 1'b1;
            end else begin
                tw_active_d = tw_in;
            end
        end else if (pend_q) begin
            // Apply on the wrap edge so the new word starts a whole period.
            // A zero active word never wraps, so it escapes unconditionally.
            if (carry || (tw_active_q == '0)) begin
                tw_active_d = tw_pend_q;
                pend_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            tw_active_q <= '0;
            tw_pend_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            tw_active_q <= tw_active_d;
            tw_pend_q   <= tw_pend_d;
            pend_q      <= pend_d;
        end
    end

    assign tw_active = tw_active_q;

    phase_acc #(
        .PA_WIDTH     (PA_WIDTH),
        .TUNE_WIDTH   (TUNE_WIDTH),
        .PA_OUT_WIDTH (PA_OUT_WIDTH)
    ) u_phase_acc (
        .clk       (clk),
        .n_RST     (n_RST),
        .en        (en),
        .tw_active (tw_active_q),
        .phase     (phase_out),
        .trig      (trig),
        .carry     (carry)
    );

endmodule : phase_trig_gen

// File: tb/tb_phase_trig_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_trig_gen
// Directed bench for phase_trig_gen at PA_WIDTH=32, TUNE_WIDTH=32,
// PA_OUT_WIDTH=8. Inputs change and outputs are sampled 1 ns after each
// rising edge; expected values are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_phase_trig_gen;

    logic        clk;
    logic        n_RST;
    logic        en;
    logic        SEL;
    logic [31:0] tw_in;
    logic        tw_valid;
    logic        tw_ready;
    logic [31:0] tw_active;
    logic [7:0]  phase_out;
    logic        trig;

    int n_checks = 0;
    int n_fail   = 0;

    phase_trig_gen #(
        .PA_WIDTH     (32),
        .TUNE_WIDTH   (32),
        .PA_OUT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .n_RST     (n_RST),
        .en        (en),
        .SEL       (SEL),
        .tw_in     (tw_in),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .tw_active (tw_active),
        .phase_out (phase_out),
        .trig      (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_RST    = 1'b0;
        en       = 1'b0;
        SEL      = 1'b0;
        tw_in    = '0;
        tw_valid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_phase",  32'(phase_out), 32'h0);
        check("rst_trig",   32'(trig),      32'h0);
        check("rst_ready",  32'(tw_ready),  32'h1);
        check("rst_active", tw_active,      32'h0);
        n_RST = 1'b1;

        // ---------------- immediate load ----------------
        // Accept edge adds the old word (0), so acc stays 0 for this cycle.
        en = 1'b1; SEL = 1'b0; tw_in = 32'h4000_0000; tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
        check("imm_active", tw_active,      32'h4000_0000);
        check("imm_phase0", 32'(phase_out), 32'h0);
        check("imm_ready",  32'(tw_ready),  32'h1);
        for (int i = 1; i <= 8; i++) begin
            step();
            check("imm_phase", 32'(phase_out), 32'((i * 32'h40) & 32'hFF));
            check("imm_trig",  32'(trig),      32'((i % 4) == 0));
        end

        // ---------------- coherent load + back-pressure ----------------
        // acc=0, word 0x40000000. Accept on the 0x40 edge; wrap three edges later.
        SEL = 1'b1; tw_in = 32'h2000_0000; tw_valid = 1'b1;
        step();
        check("coh_acc_ready",  32'(tw_ready),  32'h0);
        check("coh_acc_active", tw_active,      32'h4000_0000);
        check("coh_acc_phase",  32'(phase_out), 32'h40);
        // Keep offering a different word in immediate mode while pending.
        SEL = 1'b0; tw_in = 32'h1234_5678;
        step();
        check("bp_phase80",  32'(phase_out), 32'h80);
        check("bp_ready80",  32'(tw_ready),  32'h0);
        check("bp_active80", tw_active,      32'h4000_0000);
        step();
        check("bp_phaseC0",  32'(phase_out), 32'hC0);
        check("bp_readyC0",  32'(tw_ready),  32'h0);
        check("bp_activeC0", tw_active,      32'h4000_0000);
        step();
        check("coh_wrap_trig",   32'(trig),      32'h1);
        check("coh_wrap_phase",  32'(phase_out), 32'h00);
        check("coh_wrap_active", tw_active,      32'h2000_0000);
        check("coh_wrap_ready",  32'(tw_ready),  32'h1);
        tw_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("coh_phase", 32'(phase_out), 32'((i * 32'h20) & 32'hFF));
            check("coh_trig",  32'(trig),      32'((i % 8) == 0));
        end
        check("bp_not_taken", tw_active, 32'h2000_0000);

        // ---------------- enable gating with a pending word ----------------
        repeat (3) step();
        check("gate_pre_phase", 32'(phase_out), 32'h60);
        en = 1'b0; SEL = 1'b1; tw_in = 32'h1000_0000; tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
        check("gate_accept_ready", 32'(tw_ready), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("gate_phase",  32'(phase_out), 32'h60);
            check("gate_trig",   32'(trig),      32'h0);
            check("gate_ready",  32'(tw_ready),  32'h0);
            check("gate_active", tw_active,      32'h2000_0000);
        end
        en = 1'b1;
        for (int i = 4; i <= 7; i++) begin
            step();
            check("resume_phase", 32'(phase_out), 32'(i * 32'h20));
            check("resume_trig",  32'(trig),      32'h0);
        end
        step();
        check("resume_wrap_trig",   32'(trig),      32'h1);
        check("resume_wrap_phase",  32'(phase_out), 32'h00);
        check("resume_wrap_active", tw_active,      32'h1000_0000);
        check("resume_wrap_ready",  32'(tw_ready),  32'h1);

        // ---------------- asynchronous reset while trig is high ----------------
        #2;
        n_RST = 1'b0;
        #1;
        check("arst_trig",   32'(trig),      32'h0);
        check("arst_phase",  32'(phase_out), 32'h0);
        check("arst_active", tw_active,      32'h0);
        check("arst_ready",  32'(tw_ready),  32'h1);

        // ---------------- zero-word escape ----------------
        #1;
        n_RST = 1'b1;
        en = 1'b1; SEL = 1'b1; tw_in = 32'h1000_0000; tw_valid = 1'b1;
        step();
        tw_valid = 1'b0;
        check("zero_pend_ready",  32'(tw_ready), 32'h0);
        check("zero_pend_active", tw_active,     32'h0);
        step();
        check("zero_apply_ready",  32'(tw_ready),  32'h1);
        check("zero_apply_active", tw_active,      32'h1000_0000);
        check("zero_apply_phase",  32'(phase_out), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            step();
            check("zero_phase", 32'(phase_out), 32'((i * 32'h10) & 32'hFF));
            check("zero_trig",  32'(trig),      32'((i % 16) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_phase_trig_gen
